// File: rtl/transmisor_mensaje_pkg.sv
// Shared constants and FSM state type for the message transmitter and its UART serializer.
package transmisor_mensaje_pkg;

    localparam int NUM_CAMPOS    = 19;
    localparam int BYTES_CAMPO   = 6;
    localparam int BYTES_MENSAJE = NUM_CAMPOS * BYTES_CAMPO;
    localparam int MSG_W         = BYTES_MENSAJE * 8;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        REPOSO,
        PEDIR,
        ESPERAR,
        TRANSMITIR
    } estado_t;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 serializer for one byte; each bit lasts DIV clock cycles.
// libre is also raised during the last stop-bit cycle so the next byte can follow with no idle gap.
module uart_tx_byte #(
    parameter int DIV = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] dato,
    input  logic       cargar,
    output logic       tx,
    output logic       libre
);

    localparam int CW = $clog2(DIV);

    logic          ocup_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_q;
    logic [8:0]    sr_q;
    logic          tx_q;
    logic          fin_bit_d;

    assign fin_bit_d = (cnt_q == CW'(DIV - 1));
    assign libre     = !ocup_q || (fin_bit_d && (bit_q == 4'd9));
    assign tx        = tx_q;

    // bit_q: 0 = start, 1..8 = data LSB first, 9 = stop
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ocup_q <= 1'b0;
            cnt_q  <= '0;
            bit_q  <= '0;
            tx_q   <= 1'b1;
        end else if (cargar && libre) begin
            ocup_q <= 1'b1;
            cnt_q  <= '0;
            bit_q  <= '0;
            sr_q   <= {1'b1, dato};
            tx_q   <= 1'b0;
        end else if (ocup_q) begin
            if (fin_bit_d) begin
                cnt_q <= '0;
                if (bit_q == 4'd9) begin
                    ocup_q <= 1'b0;
                    tx_q   <= 1'b1;
                end else begin
                    bit_q <= bit_q + 4'd1;
                    tx_q  <= sr_q[0];
                    sr_q  <= {1'b1, sr_q[8:1]};
                end
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/transmisor_mensaje.sv
// Requests a BCD conversion, captures the 114-byte message on doneBCD's rising edge and sends it over UART.
// Define TERMINADOR_CRLF_EN to append CR LF after the message.
module transmisor_mensaje
    import transmisor_mensaje_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CICLOS = 65535
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             enviar,
    input  logic             doneBCD,
    input  logic [MSG_W-1:0] mensaje,
    output logic             startBCD,
    output logic             tx,
    output logic             ocupado,
    output logic             fin,
    output logic             error_timeout
);

    localparam int DIV = CLK_HZ / BAUD;
`ifdef TERMINADOR_CRLF_EN
    localparam int N_BYTES = BYTES_MENSAJE + 2;
`else
    localparam int N_BYTES = BYTES_MENSAJE;
`endif
    localparam int TW = $clog2(TIMEOUT_CICLOS + 1);

    estado_t          estado_q;
    logic             start_q, ocup_q, fin_q, err_q, done_prev_q;
    logic [TW-1:0]    tmo_q;
    logic [6:0]       idx_q;
    logic [MSG_W-1:0] buf_q;
    logic             libre, flanco_d, cargar_d;
    logic [7:0]       dato_d;

    assign flanco_d      = doneBCD && !done_prev_q;
    assign startBCD      = start_q;
    assign ocupado       = ocup_q;
    assign fin           = fin_q;
    assign error_timeout = err_q;

    // Byte 0 comes straight from mensaje so its start bit leaves right after the capture edge;
    // later bytes come from the buffer, whose top byte is always the one on the line.
    always_comb begin
        cargar_d = 1'b0;
        dato_d   = mensaje[MSG_W-1 -: 8];
        if (estado_q == ESPERAR) begin
            cargar_d = flanco_d;
        end else if (estado_q == TRANSMITIR) begin
            cargar_d = libre && (idx_q != 7'(N_BYTES - 1));
            dato_d   = buf_q[MSG_W-9 -: 8];
`ifdef TERMINADOR_CRLF_EN
            if (idx_q == 7'(BYTES_MENSAJE - 1)) begin
                dato_d = ASCII_CR;
            end else if (idx_q == 7'(BYTES_MENSAJE)) begin
                dato_d = ASCII_LF;
            end
`endif
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_uart (
        .Clock  (Clock),
        .Reset  (Reset),
        .dato   (dato_d),
        .cargar (cargar_d),
        .tx     (tx),
        .libre  (libre)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado_q    <= REPOSO;
            start_q     <= 1'b0;
            ocup_q      <= 1'b0;
            fin_q       <= 1'b0;
            err_q       <= 1'b0;
            done_prev_q <= 1'b0;
            tmo_q       <= '0;
            idx_q       <= '0;
        end else begin
            done_prev_q <= doneBCD;
            start_q     <= 1'b0;
            fin_q       <= 1'b0;
            case (estado_q)
                REPOSO: begin
                    if (enviar) begin
                        estado_q <= PEDIR;
                        start_q  <= 1'b1;
                        ocup_q   <= 1'b1;
                        err_q    <= 1'b0;
                    end
                end
                PEDIR: begin
                    estado_q <= ESPERAR;
                    tmo_q    <= '0;
                end
                ESPERAR: begin
                    if (flanco_d) begin
                        buf_q    <= mensaje;
                        idx_q    <= '0;
                        estado_q <= TRANSMITIR;
                    end else if (tmo_q == TW'(TIMEOUT_CICLOS - 1)) begin
                        err_q    <= 1'b1;
                        ocup_q   <= 1'b0;
                        estado_q <= REPOSO;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                TRANSMITIR: begin
                    if (libre) begin
                        if (idx_q == 7'(N_BYTES - 1)) begin
                            fin_q    <= 1'b1;
                            ocup_q   <= 1'b0;
                            idx_q    <= '0;
                            estado_q <= REPOSO;
                        end else begin
                            idx_q <= idx_q + 7'd1;
                            buf_q <= {buf_q[MSG_W-9:0], 8'h00};
                        end
                    end
                end
                default: estado_q <= REPOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_transmisor_mensaje.sv
// Scoreboard bench for transmisor_mensaje: a UART receiver pops expected bytes as frames arrive.
module tb_transmisor_mensaje;

    localparam int DIVB = 4;
`ifdef TERMINADOR_CRLF_EN
    localparam int NB = 116;
`else
    localparam int NB = 114;
`endif
    localparam int FRAME_CYC = NB * 10 * DIVB;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         enviar = 1'b0;
    logic         doneBCD = 1'b0;
    logic [911:0] mensaje = '0;
    logic         startBCD, tx, ocupado, fin, error_timeout;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_st = 0;
    int n_fin = 0;
    int exp_st = 0;
    logic [7:0] sb[$];

    transmisor_mensaje #(
        .CLK_HZ         (1000000),
        .BAUD           (250000),
        .TIMEOUT_CICLOS (20)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .enviar        (enviar),
        .doneBCD       (doneBCD),
        .mensaje       (mensaje),
        .startBCD      (startBCD),
        .tx            (tx),
        .ocupado       (ocupado),
        .fin           (fin),
        .error_timeout (error_timeout)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;
    always @(negedge Clock) begin
        if (startBCD === 1'b1) n_st <= n_st + 1;
        if (fin === 1'b1) n_fin <= n_fin + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic logic [7:0] byte_of(input int sel, input int k);
        string s;
        logic [7:0] r;
        s = "A+0123";
        if (sel == 0) begin
            if (k < 6) r = s[k];
            else r = 8'(8'h30 + (k % 10));
        end else if (sel == 1) begin
            r = 8'(255 - k);
        end else begin
            r = 8'(k * 3 + 1);
        end
        return r;
    endfunction

    function automatic logic [911:0] pack(input int sel);
        logic [911:0] v;
        v = '0;
        for (int k = 0; k < 114; k++) v[911 - 8*k -: 8] = byte_of(sel, k);
        return v;
    endfunction

    task automatic push_exp(input int sel);
        logic [7:0] hand[6];
        hand = '{8'h41, 8'h2B, 8'h30, 8'h31, 8'h32, 8'h33};
        for (int k = 0; k < 114; k++) begin
            if (sel == 0 && k < 6) sb.push_back(hand[k]);
            else sb.push_back(byte_of(sel, k));
        end
`ifdef TERMINADOR_CRLF_EN
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
`endif
    endtask

    task automatic wait_for(input int which, input int budget, input string nm, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 && startBCD === 1'b1) || (which == 1 && fin === 1'b1) ||
                (which == 2 && error_timeout === 1'b1)) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clock);
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL %s: no event within %0d cycles", nm, budget);
        end
    endtask

    // UART receiver / scoreboard monitor; bytes overlapped by Reset are discarded
    initial begin : rx_mon
        logic [7:0] b;
        bit         drop;
        logic       st, sp;
        forever begin
            @(negedge Clock);
            if (tx === 1'b0 && Reset === 1'b0) begin
                drop = 1'b0;
                b    = '0;
                st   = 1'b1;
                sp   = 1'b0;
                for (int c = 1; c <= 38; c++) begin
                    @(negedge Clock);
                    if (Reset !== 1'b0) drop = 1'b1;
                    if (c == 2) st = tx;
                    else if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) b[(c - 6) / 4] = tx;
                    else if (c == 38) sp = tx;
                end
                if (!drop) begin
                    chk("start bit level", st, 0);
                    chk("stop bit level", sp, 1);
                    if (sb.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected byte: got %02h required none", b);
                    end else begin
                        chk("rx byte", b, sb.pop_front());
                    end
                end
            end
        end
    end

    // mode: 0 plain, 1 mensaje change + enviar during frame, 2 doneBCD stuck high, 3 reset mid-frame
    task automatic send_frame(input int sel, input int mode);
        bit ok;
        int cap, fin0;
        mensaje = pack(sel);
        if (mode == 2) begin
            doneBCD = 1'b1;
            repeat (3) @(negedge Clock);
        end
        enviar = 1'b1;
        @(negedge Clock);
        enviar = 1'b0;
        exp_st++;
        wait_for(0, 5, "startBCD wait", ok);
        if (!ok) return;
        chk("error cleared by enviar", error_timeout, 0);
        chk("ocupado after enviar", ocupado, 1);
        @(negedge Clock);
        chk("startBCD single cycle", startBCD, 0);
        if (mode == 2) begin
            repeat (6) @(negedge Clock);
            chk("no capture while stuck high", tx, 1);
            chk("still waiting while stuck high", ocupado, 1);
            doneBCD = 1'b0;
            @(negedge Clock);
        end else begin
            repeat (9) @(negedge Clock);
        end
        push_exp(sel);
        doneBCD = 1'b1;
        cap = cyc + 1;
        @(negedge Clock);
        chk("start bit right after capture", tx, 0);
        repeat (3) @(negedge Clock);
        doneBCD = 1'b0;
        if (mode == 1) begin
            while (cyc < cap + 5*40 + 10) @(negedge Clock);
            mensaje = ~mensaje;
            enviar  = 1'b1;
            @(negedge Clock);
            enviar  = 1'b0;
        end
        if (mode == 3) begin
            while (cyc < cap + 50*40 + 13) @(negedge Clock);
            fin0  = n_fin;
            Reset = 1'b1;
            sb.delete();
            @(negedge Clock);
            chk("tx idle after reset", tx, 1);
            chk("ocupado after reset", ocupado, 0);
            chk("fin during reset", fin, 0);
            @(negedge Clock);
            Reset = 1'b0;
            repeat (60) @(negedge Clock);
            chk("no fin after abort", n_fin, fin0);
            chk("idle after abort", ocupado, 0);
            chk("tx high after abort", tx, 1);
            return;
        end
        wait_for(1, FRAME_CYC + 50, "fin wait", ok);
        if (ok) begin
            chk("fin latency", cyc - cap, FRAME_CYC);
            chk("ocupado falls with fin", ocupado, 0);
            chk("all bytes received", sb.size(), 0);
        end
        @(negedge Clock);
        chk("fin single cycle", fin, 0);
        chk("startBCD count", n_st, exp_st);
    endtask

    task automatic timeout_test();
        bit ok;
        int fin0;
        fin0 = n_fin;
        enviar = 1'b1;
        @(negedge Clock);
        enviar = 1'b0;
        exp_st++;
        wait_for(0, 5, "startBCD wait", ok);
        if (!ok) return;
        repeat (20) @(negedge Clock);
        chk("no timeout before limit", error_timeout, 0);
        chk("ocupado while waiting", ocupado, 1);
        @(negedge Clock);
        chk("timeout flag", error_timeout, 1);
        chk("ocupado after timeout", ocupado, 0);
        chk("tx after timeout", tx, 1);
        repeat (10) @(negedge Clock);
        chk("timeout flag sticky", error_timeout, 1);
        chk("no fin on timeout", n_fin, fin0);
        chk("startBCD count timeout", n_st, exp_st);
    endtask

    initial begin
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        chk("reset tx", tx, 1);
        chk("reset startBCD", startBCD, 0);
        chk("reset ocupado", ocupado, 0);
        chk("reset fin", fin, 0);
        chk("reset error_timeout", error_timeout, 0);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        send_frame(0, 1);
        timeout_test();
        send_frame(1, 2);
        send_frame(2, 3);
        send_frame(0, 0);
        repeat (5) @(negedge Clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
